// File: rtl/alu_pkg.sv
// Shared types for the ALU multi-precision compare sequencer.
// State encoding, operation bits and the flag bundle.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RESP
    } cmp_seq_state_e;

    // Bit 0 = signed, bit 1 = equality-only.
    typedef struct packed {
        logic eq_only;
        logic sgn;
    } cmp_op_t;

    typedef struct packed {
        logic cf;
        logic zf;
        logic gf;
    } cmp_flags_t;

    // Turn the accumulated decision into the flags the flag unit sees.
    function automatic cmp_flags_t cmp_final(
        input cmp_op_t op,
        input logic    decided,
        input logic    lt
    );
        cmp_flags_t f;
        f.zf = !decided;
        f.cf = decided & lt & !op.eq_only;
        f.gf = decided & !lt & !op.eq_only;
        return f;
    endfunction

endpackage

// File: rtl/cmp_seq_ctrl_if.sv
// Issue-side / flag-side bus of the compare sequencer.
// slave = the sequencer, master = issue stage plus flag register.
interface cmp_seq_ctrl_if #(
    parameter int WORD_WIDTH = 16,
    parameter int MAX_WORDS  = 4
);
    localparam int NW_W = $clog2(MAX_WORDS + 1);

    logic                  start_valid_i;
    logic                  start_ready_o;
    logic [1:0]            op_i;
    logic [NW_W-1:0]       nwords_i;
    logic                  word_valid_i;
    logic                  word_ready_o;
    logic [WORD_WIDTH-1:0] a_i;
    logic [WORD_WIDTH-1:0] b_i;
    logic                  res_valid_o;
    logic                  res_ready_i;
    logic                  cf_o;
    logic                  zf_o;
    logic                  gf_o;

    modport slave (
        input  start_valid_i, op_i, nwords_i,
        input  word_valid_i, a_i, b_i,
        input  res_ready_i,
        output start_ready_o, word_ready_o,
        output res_valid_o, cf_o, zf_o, gf_o
    );

    modport master (
        output start_valid_i, op_i, nwords_i,
        output word_valid_i, a_i, b_i,
        output res_ready_i,
        input  start_ready_o, word_ready_o,
        input  res_valid_o, cf_o, zf_o, gf_o
    );

endinterface

// File: rtl/fast_comparator.sv
// Single-word unsigned magnitude comparator.
// above = a > b, below = a < b; both low means equal.
module fast_comparator #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             above,
    output logic             below
);

    assign above = (a > b);
    assign below = (a < b);

endmodule

// File: rtl/cmp_seq_ctrl.sv
// Multi-precision compare sequencer, MSW first, one word pair per cycle.
// Optional CMP_STATS_EN adds saturating completed/early-decided counters.
module cmp_seq_ctrl
    import alu_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int MAX_WORDS  = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    cmp_seq_ctrl_if.slave bus
`ifdef CMP_STATS_EN
    ,
    output logic [15:0] stat_cmp_o,
    output logic [15:0] stat_early_o
`endif
);

    localparam int NW_W = $clog2(MAX_WORDS + 1);
    localparam logic [NW_W-1:0] ONE  = NW_W'(1);
    localparam logic [NW_W-1:0] ZERO = '0;
    localparam logic [NW_W-1:0] MAXW = NW_W'(MAX_WORDS);

    cmp_seq_state_e state;
    cmp_seq_state_e state_nxt;

    cmp_op_t         op_q;
    logic [NW_W-1:0] nw_q;
    logic [NW_W-1:0] idx_q;
    logic            decided_q;
    logic            lt_q;
    cmp_flags_t      flags_q;

    logic            start_ready;
    logic            word_ready;
    logic            res_valid;

    logic            start_hs;
    logic            word_hs;
    logic            res_hs;
    logic [NW_W-1:0] nw_in;
    logic            last;

    logic [WORD_WIDTH-1:0] flip;
    logic [WORD_WIDTH-1:0] a_w;
    logic [WORD_WIDTH-1:0] b_w;
    logic                  above;
    logic                  below;
    logic                  dec_nxt;
    logic                  lt_nxt;

    assign start_hs = bus.start_valid_i & start_ready;
    assign word_hs  = bus.word_valid_i & word_ready;
    assign res_hs   = bus.res_ready_i & res_valid;

    assign nw_in = (bus.nwords_i > MAXW) ? MAXW : bus.nwords_i;
    assign last  = (idx_q == nw_q - ONE);

    // Signed compare: biasing the top word's sign bit turns it unsigned.
    assign flip = {op_q.sgn & (idx_q == ZERO),
                   {(WORD_WIDTH-1){1'b0}}};
    assign a_w  = bus.a_i ^ flip;
    assign b_w  = bus.b_i ^ flip;

    fast_comparator #(
        .WIDTH (WORD_WIDTH)
    ) u_cmp (
        .a     (a_w),
        .b     (b_w),
        .above (above),
        .below (below)
    );

    // First differing word decides; later words cannot change it.
    assign dec_nxt = decided_q | above | below;
    assign lt_nxt  = decided_q ? lt_q : below;

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        word_ready  = 1'b0;
        res_valid   = 1'b0;
        unique case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (bus.start_valid_i)
                    state_nxt = (nw_in == ZERO) ? RESP : RUN;
            end
            RUN: begin
                word_ready = 1'b1;
                if (bus.word_valid_i && last)
                    state_nxt = RESP;
            end
            RESP: begin
                res_valid = 1'b1;
                if (bus.res_ready_i)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, decision accumulation and flag register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            op_q      <= '0;
            nw_q      <= '0;
            idx_q     <= '0;
            decided_q <= 1'b0;
            lt_q      <= 1'b0;
            flags_q   <= '0;
        end else if (start_hs) begin
            op_q      <= cmp_op_t'(bus.op_i);
            nw_q      <= nw_in;
            idx_q     <= '0;
            decided_q <= 1'b0;
            lt_q      <= 1'b0;
            if (nw_in == ZERO)
                flags_q <= cmp_final(cmp_op_t'(bus.op_i), 1'b0, 1'b0);
        end else if (word_hs) begin
            decided_q <= dec_nxt;
            lt_q      <= lt_nxt;
            if (last) begin
                idx_q   <= '0;
                flags_q <= cmp_final(op_q, dec_nxt, lt_nxt);
            end else begin
                idx_q   <= idx_q + ONE;
            end
        end
    end

    assign bus.start_ready_o = start_ready;
    assign bus.word_ready_o  = word_ready;
    assign bus.res_valid_o   = res_valid;
    assign bus.cf_o          = flags_q.cf;
    assign bus.zf_o          = flags_q.zf;
    assign bus.gf_o          = flags_q.gf;

`ifdef CMP_STATS_EN
    // Saturating counters: completed compares and early decisions.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stat_cmp_o   <= '0;
            stat_early_o <= '0;
        end else begin
            if (res_hs && stat_cmp_o != 16'hFFFF)
                stat_cmp_o <= stat_cmp_o + 16'd1;
            if (word_hs && last && decided_q &&
                stat_early_o != 16'hFFFF)
                stat_early_o <= stat_early_o + 16'd1;
        end
    end
`else
    logic unused_res_hs;
    assign unused_res_hs = res_hs;
`endif

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Directed table-driven bench for cmp_seq_ctrl.
// Covers latency, flags, clamping, stall, hold and async reset.
module tb_cmp_seq_ctrl;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cmp_seq_ctrl_if #(.WORD_WIDTH(16), .MAX_WORDS(4)) bus ();

`ifdef CMP_STATS_EN
    logic [15:0] stat_cmp;
    logic [15:0] stat_early;
`endif

    cmp_seq_ctrl #(
        .WORD_WIDTH (16),
        .MAX_WORDS  (4)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
`ifdef CMP_STATS_EN
        ,
        .stat_cmp_o   (stat_cmp),
        .stat_early_o (stat_early)
`endif
    );

    typedef struct {
        logic [1:0]       op;
        logic [2:0]       nw;
        logic [3:0][15:0] a;
        logic [3:0][15:0] b;
        bit               tog;
        int               hold;
        logic [2:0]       flg;
        bit               early;
    } vec_t;

    vec_t v[12];
    int   total = 0;
    int   bad = 0;
    int   exp_cmp = 0;
    int   exp_early = 0;

    function automatic logic [3:0][15:0] mk(
        input logic [15:0] w0, input logic [15:0] w1,
        input logic [15:0] w2, input logic [15:0] w3
    );
        return {w3, w2, w1, w0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] flags();
        return {bus.cf_o, bus.zf_o, bus.gf_o};
    endfunction

    task automatic run(input vec_t t, input string nm);
        int eff;
        int sent;
        int cyc;
        bit hs;
        eff = (t.nw > 3'd4) ? 4 : int'(t.nw);
        chk({nm, ".start_rdy"}, 32'(bus.start_ready_o), 1);
        bus.op_i = t.op;
        bus.nwords_i = t.nw;
        bus.start_valid_i = 1'b1;
        @(posedge clk); #1;
        bus.start_valid_i = 1'b0;
        sent = 0;
        cyc = 0;
        while (sent < eff && cyc < 64) begin
            bus.word_valid_i = t.tog ? (cyc % 2 == 0) : 1'b1;
            bus.a_i = t.a[sent];
            bus.b_i = t.b[sent];
            hs = bus.word_valid_i & bus.word_ready_o;
            @(posedge clk); #1;
            if (hs) sent++;
            cyc++;
        end
        if (cyc >= 64) chk({nm, ".timeout"}, sent, eff);
        bus.word_valid_i = 1'b1;
        chk({nm, ".res_lat"}, 32'(bus.res_valid_o), 1);
        chk({nm, ".wrdy_off"}, 32'(bus.word_ready_o), 0);
        chk({nm, ".flags"}, 32'(flags()), 32'(t.flg));
        for (int h = 0; h < t.hold; h++) begin
            bus.start_valid_i = 1'b1;
            @(posedge clk); #1;
            chk({nm, ".hold"},
                32'({bus.res_valid_o, bus.start_ready_o, flags()}),
                32'({2'b10, t.flg}));
        end
        bus.start_valid_i = 1'b0;
        bus.word_valid_i = 1'b0;
        bus.res_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.res_ready_i = 1'b0;
        chk({nm, ".done"},
            32'({bus.res_valid_o, bus.start_ready_o}), 32'(2'b01));
        exp_cmp++;
        if (t.early) exp_early++;
`ifdef CMP_STATS_EN
        chk({nm, ".stat_cmp"}, 32'(stat_cmp), exp_cmp);
        chk({nm, ".stat_early"}, 32'(stat_early), exp_early);
`endif
    endtask

    initial begin
        bus.start_valid_i = 1'b0;
        bus.op_i = '0;
        bus.nwords_i = '0;
        bus.word_valid_i = 1'b0;
        bus.a_i = '0;
        bus.b_i = '0;
        bus.res_ready_i = 1'b0;

        v[0]  = '{2'b00, 3'd2, mk(16'h0001, 16'hFFFF, 0, 0),
                  mk(16'h0002, 16'h0000, 0, 0), 1'b0, 1, 3'b100, 1'b1};
        v[1]  = '{2'b01, 3'd1, mk(16'h8000, 0, 0, 0),
                  mk(16'h0001, 0, 0, 0), 1'b0, 1, 3'b100, 1'b0};
        v[2]  = '{2'b00, 3'd1, mk(16'h8000, 0, 0, 0),
                  mk(16'h0001, 0, 0, 0), 1'b0, 1, 3'b001, 1'b0};
        v[3]  = '{2'b00, 3'd4,
                  mk(16'h1234, 16'h1234, 16'h1234, 16'h1234),
                  mk(16'h1234, 16'h1234, 16'h1234, 16'h1234),
                  1'b1, 1, 3'b010, 1'b0};
        v[4]  = '{2'b00, 3'd3, mk(5, 1, 2, 0), mk(3, 9, 8, 0),
                  1'b0, 1, 3'b001, 1'b1};
        v[5]  = '{2'b10, 3'd2, mk(1, 2, 0, 0), mk(1, 3, 0, 0),
                  1'b0, 1, 3'b000, 1'b0};
        v[6]  = '{2'b10, 3'd1, mk(7, 0, 0, 0), mk(7, 0, 0, 0),
                  1'b0, 1, 3'b010, 1'b0};
        v[7]  = '{2'b00, 3'd7, mk(0, 0, 0, 5), mk(0, 0, 0, 6),
                  1'b0, 1, 3'b100, 1'b0};
        v[8]  = '{2'b01, 3'd2, mk(16'hFFFF, 16'h0000, 0, 0),
                  mk(16'h0000, 16'hFFFF, 0, 0), 1'b0, 1, 3'b100, 1'b1};
        v[9]  = '{2'b01, 3'd2, mk(16'h0000, 16'h8000, 0, 0),
                  mk(16'h0000, 16'h0001, 0, 0), 1'b0, 1, 3'b001, 1'b0};
        v[10] = '{2'b10, 3'd2, mk(1, 5, 0, 0), mk(2, 5, 0, 0),
                  1'b0, 1, 3'b000, 1'b1};
        v[11] = '{2'b00, 3'd0, mk(0, 0, 0, 0), mk(0, 0, 0, 0),
                  1'b0, 5, 3'b010, 1'b0};

        #3;
        chk("reset_out",
            32'({bus.start_ready_o, bus.word_ready_o,
                 bus.res_valid_o, flags()}), 32'(6'b100000));
        #9;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++)
            run(v[i], $sformatf("v%0d", i));

        // Abort a compare mid-RUN after its first word.
        bus.op_i = 2'b00;
        bus.nwords_i = 3'd3;
        bus.start_valid_i = 1'b1;
        @(posedge clk); #1;
        bus.start_valid_i = 1'b0;
        bus.word_valid_i = 1'b1;
        bus.a_i = 16'd1;
        bus.b_i = 16'd2;
        @(posedge clk); #1;
        bus.word_valid_i = 1'b0;
        chk("mid_run", 32'({bus.word_ready_o, bus.res_valid_o}),
            32'(2'b10));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_run",
            32'({bus.start_ready_o, bus.word_ready_o,
                 bus.res_valid_o, flags()}), 32'(6'b100000));
        exp_cmp = 0;
        exp_early = 0;
`ifdef CMP_STATS_EN
        chk("rst_stats", 32'({stat_cmp, stat_early}), 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run(v[4], "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
